// File: rtl/run_length_packer_pkg.sv
// run_length_packer_pkg: packet/token types and widths shared by the run-length packer and its FIFO
package run_length_packer_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int TOKEN_W = DATA_WIDTH + 2;
  typedef enum logic [1:0] {
    PKT_DELTA = 2'b00,
    PKT_RUN   = 2'b01,
    PKT_SPIKE = 2'b10,
    PKT_LIT   = 2'b11
  } pkt_type_e;
  typedef struct packed {
    pkt_type_e             kind;
    logic [DATA_WIDTH-1:0] payload;
  } token_t;
endpackage

// File: rtl/run_length_packer_token_fifo.sv
// run_length_packer_token_fifo: show-ahead token FIFO, up to 2 pushes (wr0 then wr1) and 1 pop per cycle, with occupancy count
module run_length_packer_token_fifo
  import run_length_packer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr0,
  input  token_t                   d0,
  input  logic                     wr1,
  input  token_t                   d1,
  input  logic                     rd,
  output token_t                   q,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  token_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign q = mem[rp];
  always_ff @(posedge clk) begin
    if (wr0) mem[wp] <= d0;
    if (wr1) mem[wp + AW'(wr0)] <= d1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(wr0) + AW'(wr1);
      rp    <= rp + AW'(rd);
      count <= count + CW'(wr0) + CW'(wr1) - CW'(rd);
    end
endmodule

// File: rtl/run_length_packer.sv
// run_length_packer: coalesces zero deltas into RUN tokens, passes other packets in order through a token FIFO
module run_length_packer
  import run_length_packer_pkg::*;
#(
  parameter int RUN_MAX    = 255,
  parameter int IDLE_FLUSH = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pkt_data,
  input  logic [1:0]            pkt_type,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic                  flush_in,
  output logic [TOKEN_W-1:0]    tok_data,
  output logic                  tok_valid,
  input  logic                  tok_ready,
  output logic [15:0]           pkts_in,
  output logic [15:0]           toks_out,
  output logic                  run_pending
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] count;
  logic [DATA_WIDTH-1:0] run_len, run_inc, run_next;
  logic [15:0] idle_cnt, idle_next;
  logic accept, pop, is_zero, idle_hit, close_run, flush_run, wr0, wr1;
  token_t pkt_tok, d0, q;
  assign pkt_ready   = count <= CW'(FIFO_DEPTH - 2);
  assign accept      = pkt_valid && pkt_ready;
  assign tok_valid   = count != '0;
  assign pop         = tok_valid && tok_ready;
  assign tok_data    = q;
  assign is_zero     = pkt_type == PKT_DELTA && pkt_data == '0;
  assign run_inc     = run_len + 1'b1;
  assign run_pending = run_len != '0;
  assign idle_hit    = idle_cnt == 16'(IDLE_FLUSH - 1);
  assign close_run   = accept && is_zero && (run_inc == DATA_WIDTH'(RUN_MAX) || flush_in);
  assign flush_run   = !accept && run_pending && (flush_in || idle_hit) && count != CW'(FIFO_DEPTH);
  assign pkt_tok     = '{kind: pkt_type_e'(pkt_type), payload: pkt_data};
  always_comb begin
    wr0       = flush_run || close_run || (accept && !is_zero);
    wr1       = accept && !is_zero && run_pending;
    d0        = (accept && !is_zero && !run_pending) ? pkt_tok
              : '{kind: PKT_RUN, payload: close_run ? run_inc : run_len};
    run_next  = (accept && is_zero && !close_run) ? run_inc : wr0 ? '0 : run_len;
    idle_next = (accept || flush_run) ? '0 : (run_pending && !idle_hit) ? idle_cnt + 16'd1 : idle_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_len  <= '0;
      idle_cnt <= '0;
      pkts_in  <= '0;
      toks_out <= '0;
    end else begin
      run_len  <= run_next;
      idle_cnt <= idle_next;
      pkts_in  <= pkts_in + 16'(accept && pkts_in != 16'hFFFF);
      toks_out <= toks_out + 16'(pop && toks_out != 16'hFFFF);
    end
  run_length_packer_token_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr0   (wr0),
    .d0    (d0),
    .wr1   (wr1),
    .d1    (pkt_tok),
    .rd    (pop),
    .q     (q),
    .count (count)
  );
  assert property (@(posedge clk) disable iff (!rst_n) !(accept && pkt_type == PKT_RUN));
endmodule

// File: tb/tb_run_length_packer.sv
// tb_run_length_packer: scoreboard bench for run_length_packer with directed run/flush/backpressure/reset scenarios
module tb_run_length_packer;
  import run_length_packer_pkg::*;
  logic clk = 0, rst_n = 0, pkt_valid = 0, flush_in = 0, tok_ready = 1;
  logic [DATA_WIDTH-1:0] pkt_data = '0;
  logic [1:0] pkt_type = '0;
  logic [TOKEN_W-1:0] tok_data;
  logic pkt_ready, tok_valid, run_pending;
  logic [15:0] pkts_in, toks_out;
  int n_chk = 0, n_pass = 0, n_acc = 0, n_pop = 0;
  logic [TOKEN_W-1:0] sb [$];
  always #5 clk = ~clk;
  run_length_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pkt_data    (pkt_data),
    .pkt_type    (pkt_type),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .flush_in    (flush_in),
    .tok_data    (tok_data),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .pkts_in     (pkts_in),
    .toks_out    (toks_out),
    .run_pending (run_pending)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic exp_tok(input logic [1:0] t, input int d);
    sb.push_back({t, DATA_WIDTH'(d)});
  endtask
  always @(negedge clk)
    if (rst_n && tok_valid && tok_ready) begin
      n_pop++;
      if (sb.size() == 0) chk("extra_tok", 32'(sb.size()), 1);
      else chk("tok", 32'(tok_data), 32'(sb.pop_front()));
    end
  task automatic send(input logic [1:0] t, input int d, input logic f = 0);
    int w = 0;
    @(negedge clk);
    pkt_valid = 1;
    pkt_type  = t;
    pkt_data  = DATA_WIDTH'(d);
    flush_in  = f;
    while (!pkt_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!pkt_ready) chk("send_ready", 32'(pkt_ready), 1);
    else n_acc++;
    @(posedge clk);
    #1;
    pkt_valid = 0;
    flush_in  = 0;
  endtask
  task automatic do_flush();
    @(negedge clk);
    flush_in = 1;
    @(posedge clk);
    #1;
    flush_in = 0;
  endtask
  task automatic drain(input string tag);
    int w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    @(negedge clk);
    chk(tag, 32'(sb.size()), 0);
  endtask
  initial begin
    #12;
    chk("rst_tok_valid", 32'(tok_valid), 0);
    chk("rst_run_pending", 32'(run_pending), 0);
    chk("rst_pkt_ready", 32'(pkt_ready), 1);
    chk("rst_pkts_in", 32'(pkts_in), 0);
    chk("rst_toks_out", 32'(toks_out), 0);
    @(negedge clk);
    rst_n = 1;
    tok_ready = 0;
    exp_tok(PKT_LIT, 100);
    exp_tok(PKT_RUN, 5);
    exp_tok(PKT_DELTA, 3);
    send(PKT_LIT, 100);
    repeat (5) send(PKT_DELTA, 0);
    chk("t1_count_before", 32'(dut.count), 1);
    chk("t1_pending", 32'(run_pending), 1);
    send(PKT_DELTA, 3);
    chk("t1_count_after", 32'(dut.count), 3);
    tok_ready = 1;
    drain("t1_drain");
    exp_tok(PKT_RUN, 255);
    exp_tok(PKT_RUN, 255);
    exp_tok(PKT_RUN, 90);
    repeat (600) send(PKT_DELTA, 0);
    chk("t2_pending", 32'(run_pending), 1);
    repeat (63) @(posedge clk);
    #1;
    chk("t2_idle63_pending", 32'(run_pending), 1);
    @(posedge clk);
    #1;
    chk("t2_idle64_pending", 32'(run_pending), 0);
    drain("t2_drain");
    exp_tok(PKT_RUN, 2);
    exp_tok(PKT_SPIKE, 0);
    exp_tok(PKT_RUN, 1);
    send(PKT_DELTA, 0);
    send(PKT_DELTA, 0);
    send(PKT_SPIKE, 0);
    send(PKT_DELTA, 0);
    do_flush();
    chk("t3_pending", 32'(run_pending), 0);
    drain("t3_drain");
    tok_ready = 0;
    for (int i = 1; i <= 8; i++) exp_tok(PKT_DELTA, i);
    for (int i = 1; i <= 6; i++) send(PKT_DELTA, i);
    @(negedge clk);
    chk("t4_ready_6", 32'(pkt_ready), 1);
    send(PKT_DELTA, 7);
    repeat (3) @(negedge clk);
    chk("t4_ready_7", 32'(pkt_ready), 0);
    chk("t4_valid", 32'(tok_valid), 1);
    tok_ready = 1;
    send(PKT_DELTA, 8);
    drain("t4_drain");
    exp_tok(PKT_RUN, 4);
    repeat (3) send(PKT_DELTA, 0);
    send(PKT_DELTA, 0, 1);
    chk("t5_pending", 32'(run_pending), 0);
    drain("t5_drain");
    tok_ready = 0;
    send(PKT_LIT, 1);
    send(PKT_LIT, 2);
    send(PKT_LIT, 3);
    repeat (7) send(PKT_DELTA, 0);
    @(negedge clk);
    chk("t6_count", 32'(dut.count), 3);
    chk("t6_pkts_in", 32'(pkts_in), 32'(n_acc));
    chk("t6_toks_out", 32'(toks_out), 32'(n_pop));
    chk("t6_pending", 32'(run_pending), 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_rst_valid", 32'(tok_valid), 0);
    chk("t6_rst_pending", 32'(run_pending), 0);
    chk("t6_rst_pkts_in", 32'(pkts_in), 0);
    chk("t6_rst_toks_out", 32'(toks_out), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("t6_post_ready", 32'(pkt_ready), 1);
    tok_ready = 1;
    exp_tok(PKT_DELTA, 9);
    send(PKT_DELTA, 9);
    drain("t7_drain");
    chk("t7_pkts_in", 32'(pkts_in), 1);
    chk("t7_toks_out", 32'(toks_out), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
